// File: rtl/spaceinvaders_vram_pkg.sv
// spaceinvaders_vram_pkg: shared constants and types for the VRAM arbiter
package spaceinvaders_vram_pkg;
  localparam logic [15:0] VRAM_BASE = 16'h2400;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int VRAM_WORDS = 7168;
  localparam int VRAM_LAT = 3;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU, TAG_CPU_OOR} vram_tag_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUED, ST_DONE} cpu_state_e;
endpackage

// File: rtl/vram_req_pipe.sv
// vram_req_pipe: tag shift register steering RAM read data to the video or CPU output register
module vram_req_pipe
  import spaceinvaders_vram_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  vram_tag_e     i_tag,
  input  logic          i_vid_oor,
  input  logic [DW-1:0] i_rdata,
  output logic          o_vid_valid,
  output logic [DW-1:0] o_vid_data,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdata
);
  localparam int N = VRAM_LAT - 1;
  vram_tag_e r_tag [N];
  logic      r_oor [N];
  vram_tag_e w_tag;
  logic      w_zero;
  logic      w_cpu;
  always_comb begin
    w_tag  = r_tag[N-1];
    w_zero = r_oor[N-1] || w_tag == TAG_CPU_OOR;
    w_cpu  = w_tag == TAG_CPU || w_tag == TAG_CPU_OOR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_tag[i] <= TAG_NONE;
        r_oor[i] <= 1'b0;
      end
      o_vid_valid <= 1'b0;
      o_vid_data  <= '0;
      o_cpu_ack   <= 1'b0;
      o_cpu_rdata <= '0;
    end else begin
      r_tag[0] <= i_tag;
      r_oor[0] <= i_vid_oor;
      for (int i = 1; i < N; i++) begin
        r_tag[i] <= r_tag[i-1];
        r_oor[i] <= r_oor[i-1];
      end
      o_vid_valid <= w_tag == TAG_VID;
      o_cpu_ack   <= w_cpu;
      if (w_tag == TAG_VID) o_vid_data <= w_zero ? '0 : i_rdata;
      if (w_cpu) o_cpu_rdata <= w_zero ? '0 : i_rdata;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between fixed-latency video fetches and
// handshaked CPU accesses; video always wins the slot
module vram_arbiter
  import spaceinvaders_vram_pkg::*;
#(
  parameter int ADDR_W       = spaceinvaders_vram_pkg::ADDR_W,
  parameter int DATA_W       = spaceinvaders_vram_pkg::DATA_W,
  parameter int VRAM_WORDS   = spaceinvaders_vram_pkg::VRAM_WORDS,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic              CLK_25MHZ,
  input  logic              RESET,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic              VID_VALID,
  output logic [DATA_W-1:0] VID_DATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              STARVE
);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(VRAM_WORDS);
  localparam int WAIT_W = 3;
  cpu_state_e        r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              w_vid_oor, w_cpu_oor, w_grant, w_ram_en, w_pipe_oor;
  vram_tag_e         w_tag;
  always_comb begin
    w_vid_oor   = VID_ADDR >= LIM;
    w_cpu_oor   = CPU_ADDR >= LIM;
    w_grant     = !VID_REQ && (r_state == ST_WAIT || (r_state == ST_IDLE && CPU_REQ));
    w_ram_en    = VID_REQ ? !w_vid_oor : w_grant && !w_cpu_oor;
    w_pipe_oor  = VID_REQ && w_vid_oor;
    w_tag       = VID_REQ ? TAG_VID : w_grant ? (w_cpu_oor ? TAG_CPU_OOR : TAG_CPU) : TAG_NONE;
    w_wait_nxt  = r_state != ST_WAIT ? '0 : &r_wait ? r_wait : r_wait + 1'b1;
    w_state_nxt = r_state == ST_IDLE   ? (CPU_REQ ? (VID_REQ ? ST_WAIT : ST_ISSUED) : ST_IDLE)
                : r_state == ST_WAIT   ? (VID_REQ ? ST_WAIT : ST_ISSUED)
                : r_state == ST_ISSUED ? (CPU_ACK ? ST_DONE : ST_ISSUED)
                : ST_IDLE;
  end
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      STARVE    <= 1'b0;
      RAM_EN    <= 1'b0;
      RAM_WE    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      STARVE  <= STARVE || w_wait_nxt > WAIT_W'(CPU_MAX_WAIT);
      RAM_EN  <= w_ram_en;
      RAM_WE  <= w_grant && !w_cpu_oor && CPU_WE;
      if (w_ram_en) RAM_ADDR <= VID_REQ ? VID_ADDR : CPU_ADDR;
      if (w_ram_en && !VID_REQ) RAM_WDATA <= CPU_WDATA;
    end
  end
  vram_req_pipe #(.DW(DATA_W)) u_pipe (
    .clk        (CLK_25MHZ),
    .rst        (RESET),
    .i_tag      (w_tag),
    .i_vid_oor  (w_pipe_oor),
    .i_rdata    (RAM_RDATA),
    .o_vid_valid(VID_VALID),
    .o_vid_data (VID_DATA),
    .o_cpu_ack  (CPU_ACK),
    .o_cpu_rdata(CPU_RDATA)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table vectors, directed corner sequences and a randomized transaction-level model
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        RESET, VID_REQ, CPU_REQ, CPU_WE;
  logic [12:0] VID_ADDR, CPU_ADDR, RAM_ADDR;
  logic [7:0]  CPU_WDATA, VID_DATA, CPU_RDATA, RAM_WDATA, RAM_RDATA;
  logic        VID_VALID, CPU_ACK, RAM_EN, RAM_WE, STARVE;
  int checks = 0, failures = 0;

  always #20 clk = ~clk;

  vram_arbiter dut (
    .CLK_25MHZ(clk), .RESET(RESET),
    .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_VALID(VID_VALID), .VID_DATA(VID_DATA),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA), .STARVE(STARVE)
  );

  // Block RAM with a deterministic power-on pattern for unwritten words
  logic [7:0] ram [8192];
  bit         wr  [8192];
  function automatic logic [7:0] f(input logic [12:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction
  always @(posedge clk) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        ram[RAM_ADDR] <= RAM_WDATA;
        wr[RAM_ADDR]  <= 1'b1;
      end
      RAM_RDATA <= wr[RAM_ADDR] ? ram[RAM_ADDR] : f(RAM_ADDR);
    end
  end

  // Reference memory contents as seen by completed writes
  logic [7:0] mdl [int];
  function automatic logic [7:0] mread(input logic [12:0] a);
    if (a >= 13'd7168) return 8'h00;
    return mdl.exists(int'(a)) ? mdl[int'(a)] : f(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    VID_REQ = 0; VID_ADDR = 0; CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
  endtask

  typedef struct {
    logic        vid;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_d;
    logic        chk_d;
    logic        exp_en;
    logic        exp_we;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int lat = -1;
    logic [7:0] got = 8'h00;
    tick();
    VID_REQ = v.vid; VID_ADDR = v.addr;
    CPU_REQ = !v.vid; CPU_WE = v.we; CPU_ADDR = v.addr; CPU_WDATA = v.wd;
    for (int n = 1; n <= 6; n++) begin
      tick();
      VID_REQ = 0;
      if (n == 1) begin
        chk($sformatf("vec%0d_ram_en", idx), RAM_EN, v.exp_en);
        chk($sformatf("vec%0d_ram_we", idx), RAM_WE, v.exp_we);
        if (v.exp_en) chk($sformatf("vec%0d_ram_addr", idx), RAM_ADDR, v.addr);
      end
      if ((v.vid ? VID_VALID : CPU_ACK) && lat < 0) begin
        lat = n;
        got = v.vid ? VID_DATA : CPU_RDATA;
        CPU_REQ = 0;
      end
    end
    chk($sformatf("vec%0d_latency", idx), lat, 3);
    if (v.chk_d) chk($sformatf("vec%0d_data", idx), got, v.exp_d);
    if (v.we && v.exp_en) mdl[int'(v.addr)] = v.wd;
  endtask

  localparam int N = 600;
  logic       e_vv [8], e_ack [8], e_en [8], e_rchk [8];
  logic [7:0] e_vd [8], e_rd [8];

  initial begin
    vec_t tv [8];
    int vcyc, acyc, vi, acks, s, g, next_ok, last_vid;
    logic [7:0] rd;
    bit seen, req, granted, vid, gen;
    logic [12:0] va;

    tv[0] = '{1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0};
    tv[1] = '{1'b0, 1'b1, 13'h0100, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b1};
    tv[2] = '{1'b0, 1'b0, 13'h0100, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 13'h1C00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 1'b0, 13'h1C05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b1, 13'h1FFF, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b0, 13'h1BFF, 8'h00, 8'h4A, 1'b1, 1'b1, 1'b0};
    tv[7] = '{1'b1, 1'b0, 13'h1BFF, 8'h00, 8'h4A, 1'b1, 1'b1, 1'b0};

    idle();
    RESET = 1;
    tick(); tick();
    chk("reset_ctrl", {VID_VALID, CPU_ACK, RAM_EN, RAM_WE, STARVE}, 0);
    chk("reset_data", {VID_DATA, CPU_RDATA, RAM_ADDR, RAM_WDATA}, 0);
    RESET = 0;

    for (int i = 0; i < 8; i++) run_vec(i, tv[i]);

    // Simultaneous video and CPU request: video first, CPU one slot later
    tick();
    VID_REQ = 1; VID_ADDR = 13'h0010; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0100;
    vcyc = -1; acyc = -1; rd = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      VID_REQ = 0;
      if (VID_VALID && vcyc < 0) vcyc = n;
      if (CPU_ACK && acyc < 0) begin acyc = n; rd = CPU_RDATA; CPU_REQ = 0; end
    end
    chk("coll_vid_cycle", vcyc, 3);
    chk("coll_ack_cycle", acyc, 4);
    chk("coll_rdata", rd, 8'h3C);
    chk("coll_starve", STARVE, 0);

    // Five back-to-back video fetches starve a pending CPU read
    tick();
    VID_REQ = 1; VID_ADDR = 13'h0020; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0100;
    vi = 0; acks = 0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (VID_VALID) begin
        chk($sformatf("b2b_vid%0d_data", vi), VID_DATA, f(13'h0020 + 13'(vi)));
        chk($sformatf("b2b_vid%0d_cycle", vi), n, vi + 3);
        vi++;
      end
      if (CPU_ACK) begin
        chk("b2b_ack_cycle", n, 8);
        chk("b2b_rdata", CPU_RDATA, 8'h3C);
        CPU_REQ = 0;
        acks++;
      end
      if (n == 4) chk("b2b_starve_before", STARVE, 0);
      if (n == 5) chk("b2b_starve_after", STARVE, 1);
      if (n < 5) VID_ADDR = 13'h0020 + 13'(n);
      else VID_REQ = 0;
    end
    chk("b2b_vid_count", vi, 5);
    chk("b2b_ack_count", acks, 1);
    chk("b2b_starve_sticky", STARVE, 1);

    // Reset while a video fetch and a CPU read are in flight
    RESET = 1; tick(); RESET = 0;
    tick();
    VID_REQ = 1; VID_ADDR = 13'h0010;
    tick();
    VID_REQ = 0; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0100;
    tick();
    RESET = 1; CPU_REQ = 0;
    tick();
    RESET = 0;
    chk("rst_mid_ctrl", {VID_VALID, CPU_ACK, RAM_EN, RAM_WE, STARVE}, 0);
    chk("rst_mid_data", {VID_DATA, CPU_RDATA, RAM_ADDR, RAM_WDATA}, 0);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      seen |= VID_VALID | CPU_ACK;
    end
    chk("rst_mid_no_stale", seen, 0);

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 8; i++) begin
      e_vv[i] = 0; e_ack[i] = 0; e_en[i] = 0; e_rchk[i] = 0; e_vd[i] = 0; e_rd[i] = 0;
    end
    req = 0; granted = 0; g = 0; next_ok = 0; last_vid = -10;
    for (int k = 0; k < N + 8; k++) begin
      tick();
      s = k % 8;
      chk("rnd_vid_valid", VID_VALID, e_vv[s]);
      if (e_vv[s]) chk("rnd_vid_data", VID_DATA, e_vd[s]);
      chk("rnd_cpu_ack", CPU_ACK, e_ack[s]);
      if (e_ack[s] && e_rchk[s]) chk("rnd_cpu_rdata", CPU_RDATA, e_rd[s]);
      chk("rnd_ram_en", RAM_EN, e_en[s]);
      chk("rnd_starve", STARVE, 0);
      e_vv[s] = 0; e_ack[s] = 0; e_en[s] = 0; e_rchk[s] = 0;
      if (granted && k == g + 3) begin granted = 0; req = 0; next_ok = k + 2; end
      gen = k < N;
      vid = gen && (k - last_vid >= 2) && ($urandom_range(0, 2) == 0);
      va = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(7168, 8191)) : 13'($urandom_range(0, 31));
      if (gen && !req && k >= next_ok && $urandom_range(0, 1) == 1) begin
        req = 1;
        CPU_WE = 1'($urandom);
        CPU_ADDR = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(7168, 8191)) : 13'($urandom_range(0, 31));
        CPU_WDATA = 8'($urandom);
      end
      VID_REQ = vid; VID_ADDR = va; CPU_REQ = req;
      if (vid) begin
        last_vid = k;
        e_vv[(k + 3) % 8] = 1;
        e_vd[(k + 3) % 8] = mread(va);
        e_en[(k + 1) % 8] = va < 13'd7168;
      end else if (req && !granted) begin
        granted = 1;
        g = k;
        e_ack[(k + 3) % 8] = 1;
        e_rchk[(k + 3) % 8] = !CPU_WE;
        e_rd[(k + 3) % 8] = mread(CPU_ADDR);
        e_en[(k + 1) % 8] = CPU_ADDR < 13'd7168;
        if (CPU_WE && CPU_ADDR < 13'd7168) mdl[int'(CPU_ADDR)] = CPU_WDATA;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
